// File: rtl/ubcsd_pipe_8_0.sv
// Two-stage carry-select 9-bit subtractor (X - Y) with valid/ready flow control.
// Define UBCSD_SAT_EN to clamp results that borrow to D = 0.
module ubcsd_pipe_8_0 (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic [8:0] X,
    input  logic [8:0] Y,
    input  logic       IVLD,
    output logic       IRDY,
    output logic [8:0] D,
    output logic       B,
    output logic       OVLD,
    input  logic       ORDY
);

    logic       s1_load;
    logic       s2_load;
    logic       v1_reg;
    logic       v2_reg;
    logic [4:0] lo_reg;
    logic       co_reg;
    logic [4:0] hi_reg [2];
    logic [8:0] d_reg;
    logic       b_reg;

    logic [8:0] y_inv;
    logic [5:0] lo_sum;
    logic [4:0] hi_sum [2];
    logic [4:0] hi_sel;
    logic [8:0] d_next;
    logic       b_next;

    assign s2_load = !v2_reg || ORDY;
    assign s1_load = !v1_reg || s2_load;
    assign IRDY    = s1_load;

    assign y_inv  = ~Y;
    assign lo_sum = {1'b0, X[4:0]} + {1'b0, y_inv[4:0]} + 6'd1;

    // Upper nibble computed for both possible carry-ins; index = carry-in.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_hi
            assign hi_sum[gi] = {1'b0, X[8:5]} + {1'b0, y_inv[8:5]} + 5'(gi);
        end
    endgenerate

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            v1_reg    <= 1'b0;
            lo_reg    <= 5'd0;
            co_reg    <= 1'b0;
            hi_reg[0] <= 5'd0;
            hi_reg[1] <= 5'd0;
        end else if (s1_load) begin
            v1_reg <= IVLD;
            if (IVLD) begin
                lo_reg    <= lo_sum[4:0];
                co_reg    <= lo_sum[5];
                hi_reg[0] <= hi_sum[0];
                hi_reg[1] <= hi_sum[1];
            end
        end
    end

    always_comb begin
        hi_sel = co_reg ? hi_reg[1] : hi_reg[0];
        d_next = {hi_sel[3:0], lo_reg};
        b_next = ~hi_sel[4];
`ifdef UBCSD_SAT_EN
        if (b_next) begin
            d_next = 9'h000;
        end
`endif
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            v2_reg <= 1'b0;
            d_reg  <= 9'h000;
            b_reg  <= 1'b0;
        end else if (s2_load) begin
            v2_reg <= v1_reg;
            if (v1_reg) begin
                d_reg <= d_next;
                b_reg <= b_next;
            end
        end
    end

    assign OVLD = v2_reg;
    assign D    = d_reg;
    assign B    = b_reg;

endmodule
